// File: rtl/interrupt_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : interrupt_control_pkg
//  Purpose  : Shared constants for the PDP-8/e interrupt front end:
//             major-state encodings (F0..H3), opcode fields and the
//             device-00 processor IOT function codes.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package interrupt_control_pkg;

  // Major states of the sequencer: Fetch, Defer, Execute, Halt, 4 phases each.
  localparam logic [4:0] F0 = 5'd0;
  localparam logic [4:0] F1 = 5'd1;
  localparam logic [4:0] F2 = 5'd2;
  localparam logic [4:0] F3 = 5'd3;
  localparam logic [4:0] D0 = 5'd4;
  localparam logic [4:0] D1 = 5'd5;
  localparam logic [4:0] D2 = 5'd6;
  localparam logic [4:0] D3 = 5'd7;
  localparam logic [4:0] E0 = 5'd8;
  localparam logic [4:0] E1 = 5'd9;
  localparam logic [4:0] E2 = 5'd10;
  localparam logic [4:0] E3 = 5'd11;
  localparam logic [4:0] H0 = 5'd12;
  localparam logic [4:0] H1 = 5'd13;
  localparam logic [4:0] H2 = 5'd14;
  localparam logic [4:0] H3 = 5'd15;

  // Opcode field values (instruction[0:2]).
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;

  // instruction[0:8] of a device-00 IOT, and instruction[0:5] of CDF/CIF.
  localparam logic [8:0] IOT_DEV00  = 9'o600;
  localparam logic [5:0] MEMEXT_62X = 6'o62;

  // Device-00 function codes (instruction[9:11]).
  typedef enum logic [2:0] {
    IOT_SKON = 3'd0,
    IOT_ION  = 3'd1,
    IOT_IOF  = 3'd2,
    IOT_SRQ  = 3'd3,
    IOT_GTF  = 3'd4,
    IOT_RTF  = 3'd5,
    IOT_SGT  = 3'd6,
    IOT_CAF  = 3'd7
  } iot_fn_e;

endpackage
`default_nettype wire

// File: rtl/interrupt_control_irq_sync.sv
`default_nettype none
// ============================================================================
//  Module   : irq_sync
//  Purpose  : ORs the level-sensitive device interrupt requests and
//             registers the result (one clock of latency, never masked).
//  Ports    : clk      - system clock
//             reset    - synchronous, active-low
//             dev_irq  - device interrupt request lines [N_IRQ]
//             int_req  - registered OR of dev_irq
//  Revision : 1.0  initial release
// ============================================================================
module irq_sync #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] dev_irq,
  output logic             int_req
);

  logic r_int_req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_int_req <= 1'b0;
    end else begin
      r_int_req <= |dev_irq;
    end
  end

  assign int_req = r_int_req;

endmodule
`default_nettype wire

// File: rtl/interrupt_control.sv
`default_nettype none
// ============================================================================
//  Module   : interrupt_control
//  Purpose  : PDP-8/e interrupt-system front end. Executes the device-00
//             IOTs (SKON ION IOF SRQ GTF RTF SGT CAF), implements the
//             one-instruction ION/RTF enable delay and the CIF/RTF inhibit
//             that lasts until the next JMP/JMS.
//  Ports    : clk          - system clock
//             reset        - synchronous, active-low
//             state        - current major state from the sequencer
//             instruction  - instruction register [0:11], bit 0 = MSB
//             int_in_prog  - interrupt-in-progress from the sequencer
//             ac           - accumulator [0:11] (RTF restores gtf from ac[1])
//             dev_irq      - device interrupt requests (level)
//             int_req      - registered OR of dev_irq
//             int_ena      - interrupt enable (ION flip-flop)
//             int_inh      - interrupt inhibit
//             gtf          - greater-than flag
//             skip         - combinational skip for the current IOT
//             caf          - one-cycle clear-all-flags strobe
//  Revision : 1.0  initial release
// ============================================================================
module interrupt_control
  import interrupt_control_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       state,
  input  logic [0:11]      instruction,
  input  logic             int_in_prog,
  input  logic [0:11]      ac,
  input  logic [N_IRQ-1:0] dev_irq,
  output logic             int_req,
  output logic             int_ena,
  output logic             int_inh,
  output logic             gtf,
  output logic             skip,
  output logic             caf
);

  logic    r_int_ena;
  logic    r_ion_delay;
  logic    r_int_inh;
  logic    r_gtf;
  logic    r_caf;
  logic    r_iip_prev;

  logic    w_ena_nxt;
  logic    w_dly_nxt;
  logic    w_inh_nxt;
  logic    w_gtf_nxt;
  logic    w_caf_nxt;

  iot_fn_e w_fn;
  logic    w_iot_f3;
  logic    w_cif_f3;
  logic    w_jump_clr;
  logic    w_ack;
  logic    w_unused_ac;

  irq_sync #(
    .N_IRQ (N_IRQ)
  ) u_irq_sync (
    .clk     (clk),
    .reset   (reset),
    .dev_irq (dev_irq),
    .int_req (int_req)
  );

  assign w_fn     = iot_fn_e'(instruction[9:11]);
  assign w_iot_f3 = (state == F3) && (instruction[0:8] == IOT_DEV00);
  assign w_cif_f3 = (state == F3) && (instruction[0:5] == MEMEXT_62X) && instruction[10];

  // The inhibit is released at the point where the jump target is committed.
  assign w_jump_clr = ((state == F3) && (instruction[0:2] == OP_JMP) && !instruction[3])
                    || ((state == D3) && (instruction[0:2] == OP_JMP))
                    || ((state == E3) && (instruction[0:2] == OP_JMS));

  // Acknowledge only on the rising edge of int_in_prog seen at E0.
  assign w_ack = (state == E0) && int_in_prog && !r_iip_prev;

  // Only ac[1] feeds the design; the rest is folded away here.
  assign w_unused_ac = ^{ac[0], ac[2:11]};

  // Later assignments override earlier ones, so the list runs from lowest
  // to highest priority.
  always_comb begin
    w_ena_nxt = r_int_ena;
    w_dly_nxt = r_ion_delay;
    w_inh_nxt = r_int_inh;
    w_gtf_nxt = r_gtf;
    w_caf_nxt = 1'b0;

    if ((state == F1) && r_ion_delay) begin
      w_ena_nxt = 1'b1;
      w_dly_nxt = 1'b0;
    end

    if (w_iot_f3 && ((w_fn == IOT_ION) || (w_fn == IOT_RTF))) begin
      w_dly_nxt = 1'b1;
    end

    if (w_iot_f3 && (w_fn == IOT_RTF)) begin
      w_gtf_nxt = ac[1];
      w_inh_nxt = 1'b1;
    end

    if (w_cif_f3) begin
      w_inh_nxt = 1'b1;
    end

    if (w_jump_clr) begin
      w_inh_nxt = 1'b0;
    end

    if (w_iot_f3 && ((w_fn == IOT_SKON) || (w_fn == IOT_IOF))) begin
      w_ena_nxt = 1'b0;
      w_dly_nxt = 1'b0;
    end

    if (w_ack) begin
      w_ena_nxt = 1'b0;
      w_dly_nxt = 1'b0;
      w_inh_nxt = 1'b0;
    end

    if (w_iot_f3 && (w_fn == IOT_CAF)) begin
      w_ena_nxt = 1'b0;
      w_dly_nxt = 1'b0;
      w_inh_nxt = 1'b0;
      w_gtf_nxt = 1'b0;
      w_caf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_int_ena   <= 1'b0;
      r_ion_delay <= 1'b0;
      r_int_inh   <= 1'b0;
      r_gtf       <= 1'b0;
      r_caf       <= 1'b0;
      r_iip_prev  <= 1'b0;
    end else begin
      r_int_ena   <= w_ena_nxt;
      r_ion_delay <= w_dly_nxt;
      r_int_inh   <= w_inh_nxt;
      r_gtf       <= w_gtf_nxt;
      r_caf       <= w_caf_nxt;
      r_iip_prev  <= int_in_prog;
    end
  end

  always_comb begin
    skip = 1'b0;
    if (w_iot_f3) begin
      case (w_fn)
        IOT_SKON: skip = r_int_ena;
        IOT_SRQ:  skip = int_req;
        IOT_SGT:  skip = r_gtf;
        default:  skip = 1'b0;
      endcase
    end
  end

  assign int_ena = r_int_ena;
  assign int_inh = r_int_inh;
  assign gtf     = r_gtf;
  assign caf     = r_caf;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interrupt_control
//  Purpose  : Self-checking bench for interrupt_control. Directed scenarios
//             followed by randomized instruction streams, all compared every
//             cycle against an instruction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_interrupt_control;
  import interrupt_control_pkg::*;

  logic        clk;
  logic        reset;
  logic [4:0]  state;
  logic [0:11] instr;
  logic        iip;
  logic [0:11] ac;
  logic [7:0]  dev_irq;
  logic        int_req, int_ena, int_inh, gtf, skip, caf;

  int total = 0;
  int bad   = 0;
  bit rnd   = 0;

  // Reference model state
  logic m_req, m_ena, m_dly, m_inh, m_gtf, m_caf, m_iip_prev;

  interrupt_control #(.N_IRQ(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .instruction (instr),
    .int_in_prog (iip),
    .ac          (ac),
    .dev_irq     (dev_irq),
    .int_req     (int_req),
    .int_ena     (int_ena),
    .int_inh     (int_inh),
    .gtf         (gtf),
    .skip        (skip),
    .caf         (caf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock edge worth of architectural behaviour, by instruction class.
  task automatic model_edge();
    logic       is_iot, ack;
    logic [2:0] fn;
    if (!reset) begin
      {m_req, m_ena, m_dly, m_inh, m_gtf, m_caf, m_iip_prev} = '0;
      return;
    end
    is_iot = (state == F3) && (instr[0:8] == 9'o600);
    fn     = instr[9:11];
    ack    = (state == E0) && iip && !m_iip_prev;
    m_iip_prev = iip;
    m_req  = |dev_irq;
    m_caf  = 1'b0;
    if (ack) begin
      m_ena = 0; m_dly = 0; m_inh = 0;
    end else if (is_iot && fn == 3'd7) begin
      m_ena = 0; m_dly = 0; m_inh = 0; m_gtf = 0; m_caf = 1;
    end else begin
      if (is_iot && (fn == 3'd0 || fn == 3'd2)) begin
        m_ena = 0; m_dly = 0;
      end else if (is_iot && (fn == 3'd1 || fn == 3'd5)) begin
        m_dly = 1;
        if (fn == 3'd5) begin
          m_gtf = ac[1];
          m_inh = 1;
        end
      end else if (state == F1 && m_dly) begin
        m_ena = 1; m_dly = 0;
      end
      if (state == F3 && instr[0:5] == 6'o62 && instr[10]) m_inh = 1;
      if ((state == F3 && instr[0:2] == 3'd5 && !instr[3]) ||
          (state == D3 && instr[0:2] == 3'd5) ||
          (state == E3 && instr[0:2] == 3'd4)) m_inh = 0;
    end
  endtask

  // Apply one major state for one clock, checking skip before the edge
  // and all registered outputs after it.
  task automatic cyc(input logic [4:0] st);
    logic [2:0] fn;
    logic       exp_skip;
    if (rnd) begin
      reset = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 5) == 0) iip = ~iip;
      if ($urandom_range(0, 3) == 0) dev_irq = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
      ac = 12'($urandom);
    end
    state = st;
    #1;
    fn = instr[9:11];
    exp_skip = (st == F3) && (instr[0:8] == 9'o600) &&
               ((fn == 3'd0 && m_ena) || (fn == 3'd3 && m_req) || (fn == 3'd6 && m_gtf));
    chk("skip", skip, exp_skip);
    model_edge();
    @(posedge clk);
    #1;
    chk("int_req", int_req, m_req);
    chk("int_ena", int_ena, m_ena);
    chk("int_inh", int_inh, m_inh);
    chk("gtf", gtf, m_gtf);
    chk("caf", caf, m_caf);
  endtask

  task automatic run_instr(input logic [0:11] ins);
    logic [2:0] op;
    instr = ins;
    op = ins[0:2];
    cyc(F0); cyc(F1); cyc(F2); cyc(F3);
    if (op <= 3'd5 && ins[3]) begin
      cyc(D0); cyc(D1); cyc(D2); cyc(D3);
    end
    if (op <= 3'd4) begin
      cyc(E0); cyc(E1); cyc(E2); cyc(E3);
    end
  endtask

  initial begin
    reset = 1'b0; state = F0; instr = 12'o7000; iip = 1'b0;
    ac = 12'o0000; dev_irq = 8'hFF;
    {m_req, m_ena, m_dly, m_inh, m_gtf, m_caf, m_iip_prev} = '0;

    // Reset with requests asserted
    cyc(H0); cyc(H0);
    chk("rst_int_req", int_req, 1'b0);
    chk("rst_int_ena", int_ena, 1'b0);
    reset = 1'b1;
    cyc(H0);
    chk("req_after_rst", int_req, 1'b1);
    dev_irq = 8'h00;

    // ION then TAD: enable rises at the TAD's F1
    run_instr(12'o6001);
    chk("ion_no_ena", int_ena, 1'b0);
    instr = 12'o1200;
    cyc(F0); chk("tad_f0_ena", int_ena, 1'b0);
    cyc(F1); chk("tad_f1_ena", int_ena, 1'b1);
    cyc(F2); cyc(F3); cyc(E0); cyc(E1); cyc(E2); cyc(E3);

    // IOF, then ION immediately followed by IOF
    run_instr(12'o6002);
    run_instr(12'o6001);
    run_instr(12'o6002);
    for (int i = 0; i < 4; i++) begin
      run_instr(12'o1200);
      chk("ion_iof_ena", int_ena, 1'b0);
    end

    // Enable, then CIF followed by JMP I
    run_instr(12'o6001);
    run_instr(12'o1200);
    run_instr(12'o6212);
    chk("cif_inh", int_inh, 1'b1);
    instr = 12'o5600;
    cyc(F0); cyc(F1); cyc(F2); cyc(F3); cyc(D0); cyc(D1); cyc(D2);
    chk("jmpi_d2_inh", int_inh, 1'b1);
    cyc(D3);
    chk("jmpi_d3_inh", int_inh, 1'b0);

    // RTF with ac[1]=1, then SGT
    run_instr(12'o6002);
    ac = 12'o2000;
    run_instr(12'o6005);
    chk("rtf_gtf", gtf, 1'b1);
    chk("rtf_inh", int_inh, 1'b1);
    chk("rtf_no_ena", int_ena, 1'b0);
    instr = 12'o6006;
    cyc(F0); cyc(F1);
    chk("sgt_f1_ena", int_ena, 1'b1);
    cyc(F2);
    state = F3; #1;
    chk("sgt_skip", skip, 1'b1);
    cyc(F3);

    // Interrupt acknowledge, then CAF
    iip = 1'b1;
    cyc(E0);
    chk("ack_ena", int_ena, 1'b0);
    chk("ack_inh", int_inh, 1'b0);
    cyc(E1); cyc(E2); cyc(E3);
    run_instr(12'o6007);
    chk("caf_pulse", caf, 1'b1);
    chk("caf_gtf", gtf, 1'b0);
    cyc(F0);
    chk("caf_end", caf, 1'b0);
    iip = 1'b0;

    // Randomized instruction streams
    rnd = 1;
    for (int n = 0; n < 400; n++) begin
      logic [0:11] ins;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ins = {9'o600, 3'($urandom_range(0, 7))};
        4:          ins = ($urandom_range(0, 1) != 0) ? 12'o6212 : 12'o6233;
        5:          ins = 12'o6201;
        6:          ins = {3'd5, 9'($urandom)};
        7:          ins = {3'd4, 9'($urandom)};
        8:          ins = {3'($urandom_range(0, 3)), 9'($urandom)};
        default:    ins = {3'd7, 9'($urandom)};
      endcase
      run_instr(ins);
      if ($urandom_range(0, 15) == 0) begin
        cyc(H0); cyc(H1); cyc(H2); cyc(H3);
      end
    end
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
